// File: rtl/oam_dma_pkg.sv
// Shared state encodings and default geometry for the OAM DMA engine.
package oam_dma_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_RD   = 3'd2;
   localparam logic [2:0] ST_WAIT = 3'd3;
   localparam logic [2:0] ST_WR   = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      REQ  = ST_REQ,
      RD   = ST_RD,
      WAIT = ST_WAIT,
      WR   = ST_WR,
      DONE = ST_DONE
   } dma_state_t;

   localparam logic [15:0] DEF_DST_BASE = 16'hFE00;
   localparam int          DEF_XFER_LEN = 160;

endpackage

// File: rtl/oam_dma_engine.sv
// Copies XFER_LEN bytes from page {src_page,00} to DST_BASE; optional abort input under OAM_DMA_ABORT_EN.
// Per byte: RD, RD_LATENCY wait cycle(s), WR; RD and WR stall while m_gnt is low, all outputs registered.
module oam_dma_engine
   import oam_dma_pkg::*;
#(
   parameter logic [15:0] DST_BASE   = DEF_DST_BASE,
   parameter int          XFER_LEN   = DEF_XFER_LEN,
   parameter int          RD_LATENCY = 1
) (
   input  logic        clka,
   input  logic        rsta,
   input  logic        reg_we,
   input  logic [7:0]  reg_din,
`ifdef OAM_DMA_ABORT_EN
   input  logic        abort,
`endif
   output logic        busy,
   output logic        done,
   output logic        m_req,
   input  logic        m_gnt,
   output logic        m_ena,
   output logic        m_wea,
   output logic [15:0] m_addr,
   output logic [7:0]  m_wdata,
   input  logic [7:0]  m_rdata
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);
   localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

   dma_state_t  state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  src_page_q, src_page_d;
   logic [1:0]  lat_q, lat_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        m_req_q, m_req_d;
   logic        m_ena_q, m_ena_d;
   logic        m_wea_q, m_wea_d;
   logic [15:0] m_addr_q, m_addr_d;
   logic [7:0]  m_wdata_q, m_wdata_d;
   logic        abort_w;

`ifdef OAM_DMA_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      src_page_d = src_page_q;
      lat_d      = lat_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      m_req_d    = m_req_q;
      m_ena_d    = 1'b0;
      m_wea_d    = m_wea_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;

      case (state_q)
         IDLE: begin
            if (reg_we && !abort_w) begin
               src_page_d = reg_din;
               idx_d      = 8'h00;
               busy_d     = 1'b1;
               m_req_d    = 1'b1;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (m_gnt) state_d = RD;
         end
         RD: begin
            if (m_gnt) begin
               m_ena_d  = 1'b1;
               m_wea_d  = 1'b0;
               m_addr_d = {src_page_q, idx_q};
               lat_d    = 2'd0;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            // Grant is ignored here: the read is already in flight.
            if (lat_q == LAT_LAST) begin
               m_wdata_d = m_rdata;
               state_d   = WR;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         WR: begin
            if (m_gnt) begin
               m_ena_d  = 1'b1;
               m_wea_d  = 1'b1;
               m_addr_d = DST_BASE + {8'h00, idx_q};
               if (idx_q == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = RD;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            m_req_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A bus access already on the wires this cycle finishes; nothing new is issued.
      if (abort_w && state_q != IDLE) begin
         busy_d  = 1'b0;
         done_d  = 1'b0;
         m_req_d = 1'b0;
         m_ena_d = 1'b0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clka) begin
      if (!rsta) begin
         state_q    <= IDLE;
         idx_q      <= 8'h00;
         src_page_q <= 8'h00;
         lat_q      <= 2'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         m_req_q    <= 1'b0;
         m_ena_q    <= 1'b0;
         m_wea_q    <= 1'b0;
         m_addr_q   <= 16'h0000;
         m_wdata_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         src_page_q <= src_page_d;
         lat_q      <= lat_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         m_req_q    <= m_req_d;
         m_ena_q    <= m_ena_d;
         m_wea_q    <= m_wea_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign m_req   = m_req_q;
   assign m_ena   = m_ena_q;
   assign m_wea   = m_wea_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;

endmodule
